// File: rtl/pa_riscv.sv
// Shared fetch-side definitions: FSM state encoding, buffer depth and
// default reset vector.
package pa_riscv;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } fetchState_t;

  localparam int unsigned FETCH_DEPTH      = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_fetchBuffer.sv
// Two-entry {pc, instruction} FIFO feeding the core. Flush clears all
// entries; a push on a full buffer is only honoured alongside a pop.
module fetchBuffer
  import pa_riscv::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] pushPc,
  input  logic [31:0] pushInstr,
  output logic [31:0] headPc,
  output logic [31:0] headInstr,
  output logic [1:0]  count
);

  localparam logic [1:0] FULL = 2'(FETCH_DEPTH);

  logic [31:0] pcMem    [FETCH_DEPTH];
  logic [31:0] instrMem [FETCH_DEPTH];
  logic        rdPtr;
  logic        wrPtr;
  logic        doPush;
  logic        doPop;

  // Qualify push/pop against occupancy.
  always_comb begin
    doPop  = pop && (count != 2'd0);
    doPush = push && ((count != FULL) || doPop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!srst) begin
      pcMem    <= '{default: '0};
      instrMem <= '{default: '0};
      rdPtr    <= 1'b0;
      wrPtr    <= 1'b0;
      count    <= '0;
    end else if (flush) begin
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= '0;
    end else begin
      if (doPush) begin
        pcMem[wrPtr]    <= pushPc;
        instrMem[wrPtr] <= pushInstr;
        wrPtr           <= ~wrPtr;
      end
      if (doPop) begin
        rdPtr <= ~rdPtr;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign headPc    = pcMem[rdPtr];
  assign headInstr = instrMem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word reads, tracks in-flight
// requests, buffers returned instructions and handles redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN enables misaligned-redirect faulting.
module fetch_unit
  import pa_riscv::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_srst,
  output logic        o_memReq,
  output logic [31:0] o_memAddress,
  input  logic        i_memGnt,
  input  logic        i_memValid,
  input  logic [31:0] i_memData,
  output logic        o_instrValid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_instrReady,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_fault
);

  fetchState_t state;
  logic [31:0] fetchPc;
  logic [31:0] respPc;
  logic [31:0] targetPc;
  logic [1:0]  outstanding;
  logic [1:0]  outstandingNext;
  logic [1:0]  dropCount;
  logic [1:0]  count;
  logic        grant;
  logic        respValid;
  logic        respDrop;
  logic        push;
  logic        pop;
  logic        redirectTake;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        faultReg;
`endif

  // Request, response and redirect qualification.
  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    targetPc = i_redirectPc;
`else
    targetPc = i_redirectPc & 32'hFFFF_FFFC;
`endif
    redirectTake = i_redirect && (state != S_FAULT);
    o_memReq     = (state == S_RUN) && !i_redirect &&
                   (({1'b0, outstanding} + {1'b0, count}) < 3'd2);
    grant        = o_memReq && i_memGnt;
    respValid    = i_memValid && (outstanding != 2'd0);
    respDrop     = respValid && (dropCount != 2'd0);
    push         = respValid && !respDrop && !redirectTake && (state != S_FAULT);
    pop          = o_instrValid && i_instrReady;
    case ({grant, respValid})
      2'b10:   outstandingNext = outstanding + 2'd1;
      2'b01:   outstandingNext = outstanding - 2'd1;
      default: outstandingNext = outstanding;
    endcase
  end

  // FSM, fetch pointer and in-flight bookkeeping. Responses return in order
  // and live requests are always sequential from the last redirect target, so
  // a single running respPc stands in for a per-request pc queue.
  always_ff @(posedge i_clk) begin
    if (!i_srst) begin
      state       <= S_RESET;
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCount   <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      faultReg    <= 1'b0;
`endif
    end else begin
      outstanding <= outstandingNext;
      if (state == S_RESET) begin
        state <= S_RUN;
      end
      if (redirectTake) begin
        fetchPc   <= targetPc;
        respPc    <= targetPc;
        dropCount <= outstandingNext;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (i_redirectPc[1:0] != 2'b00) begin
          state    <= S_FAULT;
          faultReg <= 1'b1;
        end
`endif
      end else begin
        if (grant) begin
          fetchPc <= fetchPc + 32'd4;
        end
        if (respDrop) begin
          dropCount <= dropCount - 2'd1;
        end
        if (push) begin
          respPc <= respPc + 32'd4;
        end
      end
    end
  end

  fetchBuffer u_buffer (
    .clk       (i_clk),
    .srst      (i_srst),
    .push      (push),
    .pop       (pop),
    .flush     (redirectTake),
    .pushPc    (respPc),
    .pushInstr (i_memData),
    .headPc    (o_pc),
    .headInstr (o_instruction),
    .count     (count)
  );

  assign o_memAddress = fetchPc;
  assign o_instrValid = (count != 2'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_fault = faultReg;
`else
  assign o_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model (configurable
// grant and response release) and a consumer-side capture queue.
module tb_fetch_unit;
  import pa_riscv::*;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic        memReq;
  logic [31:0] memAddress;
  logic        memGnt = 1'b0;
  logic        memValid = 1'b0;
  logic [31:0] memData = '0;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instrReady = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        fault;

  logic        gntEnable = 1'b1;
  logic        respEnable = 1'b1;
  logic [31:0] memQ[$];
  logic [31:0] seenPc[$];
  logic [31:0] seenInstr[$];

  int unsigned nChecks = 0;
  int unsigned nFails = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_srst        (srst),
    .o_memReq      (memReq),
    .o_memAddress  (memAddress),
    .i_memGnt      (memGnt),
    .i_memValid    (memValid),
    .i_memData     (memData),
    .o_instrValid  (instrValid),
    .o_instruction (instruction),
    .o_pc          (pc),
    .i_instrReady  (instrReady),
    .i_redirect    (redirect),
    .i_redirectPc  (redirectPc),
    .o_fault       (fault)
  );

  initial forever #5 clk = ~clk;

  // In-order memory: answers granted requests no earlier than the next cycle.
  initial forever begin
    @(negedge clk);
    #1;
    if (!srst) begin
      memQ.delete();
      memValid = 1'b0;
    end else begin
      if (respEnable && memQ.size() > 0) begin
        memValid = 1'b1;
        memData  = memQ.pop_front() ^ KEY;
      end else begin
        memValid = 1'b0;
        memData  = '0;
      end
      memGnt = gntEnable;
      if (memReq && memGnt) memQ.push_back(memAddress);
    end
  end

  // Capture what the core consumes at the coming edge.
  initial forever begin
    @(negedge clk);
    #3;
    if (srst && instrValid && instrReady) begin
      seenPc.push_back(pc);
      seenInstr.push_back(instruction);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d checks required completion", nChecks);
    $fatal(1, "watchdog");
  end

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("FAIL %s: actual %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] seenPcAt(input int unsigned i);
    return (i < seenPc.size()) ? seenPc[i] : 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] seenInstrAt(input int unsigned i);
    return (i < seenInstr.size()) ? seenInstr[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic clearSeen();
    seenPc.delete();
    seenInstr.delete();
  endtask

  // Hold reset, check reset outputs, release; returns in the first cycle after release.
  task automatic doReset(input logic rdy);
    @(negedge clk);
    srst = 1'b0; redirect = 1'b0; instrReady = rdy; gntEnable = 1'b1; respEnable = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checkEq("rst_memReq", 32'(memReq), 32'd0);
    checkEq("rst_memAddress", memAddress, 32'h0);
    checkEq("rst_instrValid", 32'(instrValid), 32'd0);
    checkEq("rst_instruction", instruction, 32'h0);
    checkEq("rst_pc", pc, 32'h0);
    checkEq("rst_fault", 32'(fault), 32'd0);
    @(negedge clk);
    srst = 1'b1;
    clearSeen();
    #2;
    checkEq("rel_cycle_memReq", 32'(memReq), 32'd0);
  endtask

  task automatic waitConsumed(input string tag, input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (seenPc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkEq({tag, "_count"}, 32'(seenPc.size()), 32'(n));
  endtask

  initial begin
    // Latency and back-to-back sequence.
    doReset(1'b1);
    @(negedge clk); #2;
    checkEq("lat_memReq", 32'(memReq), 32'd1);
    checkEq("lat_memAddress", memAddress, 32'h0);
    @(negedge clk); #2;
    checkEq("lat_respCycle_valid", 32'(instrValid), 32'd0);
    @(negedge clk); #2;
    checkEq("lat_valid", 32'(instrValid), 32'd1);
    checkEq("lat_pc", pc, 32'h0);
    waitConsumed("seq", 4, 40);
    for (int i = 0; i < 4; i++) begin
      checkEq("seq_pc", seenPcAt(i), 32'(4 * i));
      checkEq("seq_instr", seenInstrAt(i), 32'(4 * i) ^ KEY);
    end

    // Core stall with full buffer.
    doReset(1'b0);
    repeat (10) @(negedge clk);
    #2;
    checkEq("stall_valid", 32'(instrValid), 32'd1);
    checkEq("stall_pc", pc, 32'h0);
    checkEq("stall_instr", instruction, KEY);
    checkEq("stall_memReq", 32'(memReq), 32'd0);
    @(negedge clk);
    instrReady = 1'b1;
    waitConsumed("stall_rel", 3, 30);
    for (int i = 0; i < 3; i++) begin
      checkEq("stall_rel_pc", seenPcAt(i), 32'(4 * i));
    end

    // Address held while grant is withheld.
    doReset(1'b1);
    @(negedge clk);
    gntEnable = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkEq("hold_memReq", 32'(memReq), 32'd1);
    checkEq("hold_addr", memAddress, 32'h0);
    @(negedge clk);
    gntEnable = 1'b1;
    #2;
    checkEq("hold_addr2", memAddress, 32'h0);
    @(negedge clk); #2;
    checkEq("hold_addr_next", memAddress, 32'h4);

    // Redirect with two requests in flight.
    doReset(1'b0);
    @(negedge clk);
    respEnable = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    checkEq("two_out_memReq", 32'(memReq), 32'd0);
    checkEq("two_out_valid", 32'(instrValid), 32'd0);
    @(negedge clk);
    redirect = 1'b1; redirectPc = 32'h100;
    #2;
    checkEq("redir_cycle_memReq", 32'(memReq), 32'd0);
    @(negedge clk);
    redirect = 1'b0; respEnable = 1'b1; instrReady = 1'b1;
    clearSeen();
    #2;
    checkEq("redir_addr", memAddress, 32'h100);
    waitConsumed("redir", 1, 30);
    checkEq("redir_pc", seenPcAt(0), 32'h100);
    checkEq("redir_instr", seenInstrAt(0), 32'h100 ^ KEY);

    // Redirect coinciding with a response and a pop.
    doReset(1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1; redirectPc = 32'h200; instrReady = 1'b1;
    #2;
    checkEq("coin_pre_valid", 32'(instrValid), 32'd1);
    checkEq("coin_pre_pc", pc, 32'h0);
    @(negedge clk);
    redirect = 1'b0;
    clearSeen();
    #2;
    checkEq("coin_empty", 32'(instrValid), 32'd0);
    checkEq("coin_addr", memAddress, 32'h200);
    checkEq("coin_memReq", 32'(memReq), 32'd1);
    waitConsumed("coin", 1, 30);
    checkEq("coin_pc", seenPcAt(0), 32'h200);

    // Fetch pointer wraps at the top of the address space.
    doReset(1'b1);
    repeat (3) @(negedge clk);
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    clearSeen();
    #2;
    checkEq("wrap_addr0", memAddress, 32'hFFFF_FFFC);
    begin
      int unsigned k = 0;
      while (!(memReq && memGnt) && k < 10) begin
        @(negedge clk); #2;
        k++;
      end
    end
    checkEq("wrap_grant", 32'(memReq && memGnt), 32'd1);
    @(negedge clk); #2;
    checkEq("wrap_addr1", memAddress, 32'h0);
    waitConsumed("wrap", 2, 30);
    checkEq("wrap_pc0", seenPcAt(0), 32'hFFFF_FFFC);
    checkEq("wrap_pc1", seenPcAt(1), 32'h0);

    // Misaligned redirect target.
    doReset(1'b1);
    repeat (3) @(negedge clk);
    redirect = 1'b1; redirectPc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    clearSeen();
`ifdef FETCH_MISALIGN_CHECK_EN
    repeat (5) @(negedge clk);
    #2;
    checkEq("mis_fault", 32'(fault), 32'd1);
    checkEq("mis_memReq", 32'(memReq), 32'd0);
    checkEq("mis_valid", 32'(instrValid), 32'd0);
`else
    #2;
    checkEq("mis_fault", 32'(fault), 32'd0);
    waitConsumed("mis", 1, 30);
    checkEq("mis_pc", seenPcAt(0), 32'h100);
    checkEq("mis_instr", seenInstrAt(0), 32'h100 ^ KEY);
`endif
    doReset(1'b1);
    @(negedge clk); #2;
    checkEq("post_fault_memReq", 32'(memReq), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_srst  input  1  synchronous, active-low reset.
REQ-004 o_memReq  output  1  instruction-memory read request.
REQ-005 o_memAddress  output  32  word address of the request; held stable while o_memReq=1 and i_memGnt=0.
REQ-006 i_memGnt  input  1  request accepted this cycle.
REQ-007 i_memValid  input  1  read data returned this cycle, in request order, earliest one cycle after grant.
REQ-008 i_memData  input  32  returned instruction word.
REQ-009 o_instrValid  output  1  o_instruction/o_pc valid for the core.
REQ-010 o_instruction  output  32  instruction at head of buffer.
REQ-011 o_pc  output  32  address of o_instruction.
REQ-012 i_instrReady  input  1  core consumes head when o_instrValid=1.
REQ-013 i_redirect  input  1  taken branch/jump; flush and refetch.
REQ-014 i_redirectPc  input  32  new fetch address, sampled when i_redirect=1.
REQ-015 o_fault  output  1  misaligned redirect target (REQ-032 only).

Function
REQ-016 Buffer: 2-entry FIFO of {pc, instruction}; head drives o_instruction/o_pc; o_instrValid = count!=0.
REQ-017 Outstanding counter 0..2; requests issue only when outstanding + count < 2, so every response always fits.
REQ-018 Handshake: o_memReq=1, i_memGnt=1 -> outstanding+1, fetchPc += 4 (wraps modulo 2^32).
REQ-019 Response with dropCount=0 -> push {pcQueue head, i_memData}; outstanding-1.
REQ-020 Response with dropCount>0 -> discard, dropCount-1, outstanding-1.
REQ-021 Pop on o_instrValid && i_instrReady; push and pop same cycle -> count unchanged.
REQ-022 Redirect: FIFO flushed, dropCount <= outstanding (including a grant or minus a response in the same cycle), fetchPc <= i_redirectPc; o_memReq=0 that cycle.
REQ-023 Redirect wins over simultaneous pop, push and grant; granted request in redirect cycle becomes stale.
REQ-024 FSM states: S_RESET (one cycle after reset release, no request), S_RUN (normal), S_FAULT (macro only); S_RESET->S_RUN unconditionally.
REQ-025 Latency: RESET_PC request in 2nd cycle after release; with 1-cycle memory, o_instrValid rises 2 cycles after grant... exactly: grant cycle N, response N+1, o_instrValid at N+2.
REQ-026 Core stall (i_instrReady=0) with FIFO full -> o_memReq=0, no data lost.

Reset
REQ-027 While i_srst=0: o_memReq=0, o_memAddress=RESET_PC, o_instrValid=0, o_instruction=0, o_pc=0, o_fault=0, count=0, outstanding=0, dropCount=0, fetchPc=RESET_PC, state=S_RESET.
REQ-028 Reset mid-transaction: in-flight responses after release are discarded; memory guarantees none arrive after reset.
REQ-029 i_memValid with outstanding=0 is ignored.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN selects misaligned-redirect checking.
REQ-031 Undefined: i_redirectPc[1:0] ignored (forced to 0); o_fault tied 0; no S_FAULT.
REQ-032 Defined: redirect with i_redirectPc[1:0]!=0 -> flush, S_FAULT, o_fault=1, no further requests until reset.

Structure
REQ-033 Package pa_riscv holds fetch FSM state enum, FIFO depth constant (2) and RESET_PC default.
REQ-034 Sub-module fetchBuffer: 2-entry {pc, instruction} FIFO with push/pop/flush, count output.

Verification
REQ-035 Reset release, 1-cycle memory, i_instrReady=1 -> o_pc sequence 0,4,8,C back-to-back with matching i_memData.
REQ-036 i_instrReady=0 for 10 cycles -> two instructions buffered, o_memReq=0, pc 0 held; release -> 0,4,8 in order.
REQ-037 Redirect to 32'h100 with 2 outstanding -> two responses discarded, next o_pc=32'h100.
REQ-038 Redirect same cycle as response and pop -> FIFO empty next cycle, response dropped, o_memAddress=i_redirectPc.
REQ-039 fetchPc 32'hFFFF_FFFC -> next o_memAddress 32'h0000_0000.
REQ-040 Macro defined, redirect to 32'h102 -> o_fault=1, o_memReq=0 until i_srst=0; undefined -> fetch 32'h100.
